conv_encoder: RTL and testbench

Rate-1/2, 8-state (constraint length 4) convolutional encoder for the transmit side of the Viterbi link. It produces the coded symbol pairs that the decoder's branch-metric units consume. It accepts one information bit per handshake and emits one registered 2-bit symbol pair per bit. Optionally it appends zero tail bits so every frame ends in state 0, which the decoder's traceback expects.

---
 rtl/conv_encoder.sv | 123 ++++++++++++
 tb/tb_conv_encoder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_encoder.sv
// rtl/conv_encoder.sv - rate-1/2, K=4 convolutional encoder with a registered symbol-pair output
// Define CONV_ENC_TAIL_EN to append three zero tail pairs so each frame ends in state 0.
module conv_encoder #(
  parameter logic [3:0] G0       = 4'b1111,
  parameter logic [3:0] G1       = 4'b1101,
  parameter logic       INV_SYM1 = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_pair,
  output logic       out_last,
  output logic       busy
);

  logic [2:0] r_s;
  logic [1:0] r_pair;
  logic       r_valid;
  logic       r_last;

  logic       w_slot_free;
  logic       w_load;
  logic       w_b;
  logic       w_pair_last;
  logic       w_clear_s;
  logic [3:0] w_taps;
  logic [1:0] w_pair;

  assign w_slot_free = !r_valid || out_ready;
  assign w_taps      = {w_b, r_s};
  assign w_pair      = {(^(w_taps & G1)) ^ INV_SYM1, ^(w_taps & G0)};

`ifdef CONV_ENC_TAIL_EN
  typedef enum logic {ST_DATA, ST_TAIL} state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [1:0] r_tail_cnt;
  logic [1:0] w_next_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_DATA;
      r_tail_cnt <= 2'd0;
    end else begin
      r_state    <= w_next_state;
      r_tail_cnt <= w_next_cnt;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_tail_cnt;
    w_load       = 1'b0;
    w_b          = 1'b0;
    w_pair_last  = 1'b0;
    in_ready     = 1'b0;
    busy         = 1'b0;
    case (r_state)
      ST_DATA: begin
        in_ready = w_slot_free;
        if (in_valid && w_slot_free) begin
          w_load = 1'b1;
          w_b    = in_bit;
          if (in_last) begin
            w_next_state = ST_TAIL;
            w_next_cnt   = 2'd2;
          end
        end
      end
      ST_TAIL: begin
        busy = 1'b1;
        // Zero bits flush the register; the third one lands s back at 000.
        if (w_slot_free) begin
          w_load = 1'b1;
          if (r_tail_cnt == 2'd0) begin
            w_pair_last  = 1'b1;
            w_next_state = ST_DATA;
          end else begin
            w_next_cnt = r_tail_cnt - 2'd1;
          end
        end
      end
      default: w_next_state = ST_DATA;
    endcase
  end

  assign w_clear_s = 1'b0;
`else
  assign in_ready    = w_slot_free;
  assign w_load      = in_valid && w_slot_free;
  assign w_b         = in_bit;
  assign w_pair_last = in_last;
  assign w_clear_s   = in_last;
  assign busy        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s     <= 3'b000;
      r_pair  <= 2'b00;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_load) begin
      r_pair  <= w_pair;
      r_last  <= w_pair_last;
      r_valid <= 1'b1;
      r_s     <= w_clear_s ? 3'b000 : {w_b, r_s[2:1]};
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_pair  = r_pair;
  assign out_last  = r_last;

endmodule

// File: tb/tb_conv_encoder.sv
// tb/tb_conv_encoder.sv - self-checking bench for conv_encoder (default and INV_SYM1=1 instances)
module tb_conv_encoder;

  localparam logic [3:0] MG0 = 4'b1111;
  localparam logic [3:0] MG1 = 4'b1101;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b1;

  logic       in_ready0, out_valid0, out_last0, busy0;
  logic [1:0] out_pair0;
  logic       in_ready1, out_valid1, out_last1, busy1;
  logic [1:0] out_pair1;

  int n_pass = 0;
  int n_total = 0;
  int busy_cnt = 0;

  logic [2:0] exp_q[$];
  logic       frame_bits[$];
  logic [2:0] cap0[$];
  logic [2:0] cap1[$];

  conv_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_bit(in_bit), .in_last(in_last), .out_valid(out_valid0),
    .out_ready(out_ready), .out_pair(out_pair0), .out_last(out_last0), .busy(busy0)
  );

  conv_encoder #(.INV_SYM1(1'b1)) dut_inv (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_bit(in_bit), .in_last(in_last), .out_valid(out_valid1),
    .out_ready(out_ready), .out_pair(out_pair1), .out_last(out_last1), .busy(busy1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Convolution over the frame's bit history: tap k looks k bits into the past.
  function automatic logic [1:0] model_pair(input logic b);
    logic [3:0] taps;
    int n;
    n = frame_bits.size();
    taps[3] = b;
    for (int k = 1; k <= 3; k++) taps[3-k] = (n >= k) ? frame_bits[n-k] : 1'b0;
    return {^(taps & MG1), ^(taps & MG0)};
  endfunction

  function automatic void model_accept(input logic b, input logic last);
`ifdef CONV_ENC_TAIL_EN
    exp_q.push_back({1'b0, model_pair(b)});
    frame_bits.push_back(b);
    if (last) begin
      for (int t = 0; t < 3; t++) begin
        exp_q.push_back({(t == 2), model_pair(1'b0)});
        frame_bits.push_back(1'b0);
      end
      frame_bits.delete();
    end
`else
    exp_q.push_back({last, model_pair(b)});
    frame_bits.push_back(b);
    if (last) frame_bits.delete();
`endif
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid0) begin
        chk("pending_pairs", (exp_q.size() != 0), 1'b1);
        if (exp_q.size() != 0) begin
          chk("pair", out_pair0, exp_q[0][1:0]);
          chk("last", out_last0, exp_q[0][2]);
        end
      end
      if (out_valid1 && exp_q.size() != 0) begin
        chk("pair_inv", out_pair1, exp_q[0][1:0] ^ 2'b10);
        chk("last_inv", out_last1, exp_q[0][2]);
      end
      if (out_valid1 && out_ready) cap1.push_back({out_last1, out_pair1});
      if (out_valid0 && out_ready) begin
        cap0.push_back({out_last0, out_pair0});
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (busy0) begin
        busy_cnt++;
        chk("ready_in_tail", in_ready0, 1'b0);
      end
      if (in_valid && in_ready0) model_accept(in_bit, in_last);
    end
  end

  task automatic send_bit(input logic b, input logic last);
    int k;
    k = 0;
    in_valid = 1'b1;
    in_bit   = b;
    in_last  = last;
    @(negedge clk);
    while (!in_ready0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("accept_timeout", in_ready0, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    do begin
      @(posedge clk);
      #2;
      k++;
    end while ((exp_q.size() != 0 || out_valid0) && k < 100);
    chk("drain_pending", exp_q.size(), 0);
  endtask

  task automatic chk_cap(input string name, input int which, input int n, input logic [15:0] pairs);
    int sz;
    logic [2:0] got;
    sz = (which == 0) ? cap0.size() : cap1.size();
    chk($sformatf("%s_len", name), sz, n);
    for (int i = 0; i < n && i < sz; i++) begin
      got = (which == 0) ? cap0[i] : cap1[i];
      chk($sformatf("%s_pair%0d", name, i), got[1:0], pairs[2*(n-1-i) +: 2]);
      chk($sformatf("%s_last%0d", name, i), got[2], (i == n-1));
    end
  endtask

  task automatic clear_caps();
    cap0.delete();
    cap1.delete();
    busy_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    #1;
    chk("rst_valid", out_valid0, 1'b0);
    chk("rst_pair", out_pair0, 2'b00);
    chk("rst_last", out_last0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_valid_inv", out_valid1, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", in_ready0, 1'b1);
    @(posedge clk);
    #1;

    // Frame 1,0,1 from reset
    clear_caps();
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b1);
    drain();
`ifdef CONV_ENC_TAIL_EN
    chk_cap("frameA", 0, 6, 16'b0000_11_11_10_00_01_11);
    chk_cap("frameA_inv", 1, 6, 16'b0000_01_01_00_10_11_01);
    chk("tail_busy_cycles", busy_cnt, 3);
`else
    chk_cap("frameA", 0, 3, 16'b0000000000_11_11_10);
    chk_cap("frameA_inv", 1, 3, 16'b0000000000_01_01_00);
    chk("notail_busy_cycles", busy_cnt, 0);
`endif

    // Single-bit frame: state must restart at 000
    clear_caps();
    send_bit(1'b1, 1'b1);
    drain();
`ifdef CONV_ENC_TAIL_EN
    chk_cap("frameB", 0, 4, 16'b00000000_11_11_01_11);
    chk_cap("frameB_inv", 1, 4, 16'b00000000_01_01_11_01);
`else
    chk_cap("frameB", 0, 1, 16'b00000000000000_11);
    chk_cap("frameB_inv", 1, 1, 16'b00000000000000_01);
`endif

    // Backpressure: stall four cycles after the first pair
    clear_caps();
    out_ready = 1'b0;
    send_bit(1'b1, 1'b0);
    fork
      send_bit(1'b0, 1'b0);
      begin
        repeat (4) begin
          @(negedge clk);
          chk("hold_pair", out_pair0, 2'b11);
          chk("hold_pair_inv", out_pair1, 2'b01);
          chk("hold_valid", out_valid0, 1'b1);
          chk("hold_ready", in_ready0, 1'b0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    send_bit(1'b1, 1'b1);
    drain();
`ifdef CONV_ENC_TAIL_EN
    chk_cap("bp", 0, 6, 16'b0000_11_11_10_00_01_11);
`else
    chk_cap("bp", 0, 3, 16'b0000000000_11_11_10);
`endif

    // Reset while a pair is pending (mid-tail when the tail is built in)
    clear_caps();
`ifdef CONV_ENC_TAIL_EN
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("busy_mid_tail", busy0, 1'b1);
`else
    out_ready = 1'b0;
    send_bit(1'b1, 1'b1);
`endif
    rst = 1'b1;
    #1;
    chk("rst_async_valid", out_valid0, 1'b0);
    chk("rst_async_busy", busy0, 1'b0);
    chk("rst_async_last", out_last0, 1'b0);
    chk("rst_async_valid_inv", out_valid1, 1'b0);
    exp_q.delete();
    frame_bits.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("ready_after_rst2", in_ready0, 1'b1);
    @(posedge clk);
    #1;
    clear_caps();
    send_bit(1'b1, 1'b1);
    drain();
`ifdef CONV_ENC_TAIL_EN
    chk_cap("post_rst", 0, 4, 16'b00000000_11_11_01_11);
`else
    chk_cap("post_rst", 0, 1, 16'b00000000000000_11);
`endif

    // Streaming: 16 random bits, no bubbles
    clear_caps();
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_bit   = 1'($urandom_range(0, 1));
      in_last  = (i == 15);
      @(negedge clk);
      chk("stream_ready", in_ready0, 1'b1);
      if (i > 0) chk("stream_valid", out_valid0, 1'b1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    drain();
`ifdef CONV_ENC_TAIL_EN
    chk("stream_pairs", cap0.size(), 19);
`else
    chk("stream_pairs", cap0.size(), 16);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
